// File: rtl/counter_pkg.sv
// Shared types and constants for the up/down counter and its optional
// sequential binary-to-BCD converter.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } bcd_state_t;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] BCD_ADD_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADD_INC    = 4'd3;

endpackage

// File: rtl/bcd_seq.sv
// Sequential double-dabble converter: snapshots the count, shifts it through
// the BCD digits one bit per cycle, then publishes the result.
module bcd_seq
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              i_q,
  input  logic [WIDTH-1:0]              i_q_nxt,
  output logic [BCD_DIGIT_W*DIGITS-1:0] o_bcd,
  output logic                          o_bcd_valid
);

  localparam int LP_BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int LP_CNT_W = $clog2(WIDTH + 1);

  bcd_state_t                  r_state;
  logic [WIDTH-1:0]            r_snap;
  logic [LP_BCD_W+WIDTH-1:0]   r_shift;
  logic [LP_CNT_W-1:0]         r_cnt;
  logic [LP_BCD_W-1:0]         r_bcd;
  logic                        r_valid;
  logic [LP_BCD_W-1:0]         w_adj;
  logic [LP_BCD_W+WIDTH-1:0]   w_shift_nxt;

  function automatic logic [LP_BCD_W-1:0] add3_digits(input logic [LP_BCD_W-1:0] v);
    logic [LP_BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i*BCD_DIGIT_W +: BCD_DIGIT_W] >= BCD_ADD_THRESH)
        r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = v[i*BCD_DIGIT_W +: BCD_DIGIT_W] + BCD_ADD_INC;
    end
    return r;
  endfunction

  assign w_adj       = add3_digits(r_shift[LP_BCD_W+WIDTH-1:WIDTH]);
  assign w_shift_nxt = {w_adj, r_shift[WIDTH-1:0]} << 1;

  // Valid is computed from the counter's next value so it lines up with q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_snap  <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_valid <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_q != r_snap) begin
            r_snap  <= i_q;
            r_shift <= {{LP_BCD_W{1'b0}}, i_q};
            r_cnt   <= LP_CNT_W'(WIDTH);
            r_state <= ST_SHIFT;
            r_valid <= 1'b0;
          end else begin
            r_valid <= (i_q_nxt == r_snap);
          end
        end
        ST_SHIFT: begin
          r_shift <= w_shift_nxt;
          r_cnt   <= r_cnt - 1'b1;
          r_valid <= 1'b0;
          if (r_cnt == LP_CNT_W'(1)) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_bcd   <= r_shift[LP_BCD_W+WIDTH-1:WIDTH];
          r_state <= ST_IDLE;
          r_valid <= (i_q_nxt == r_snap);
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_bcd       = r_bcd;
  assign o_bcd_valid = r_valid;

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down modulo-MOD counter with clamped parallel load and wrap pulse.
// Define MOD_COUNTER_BCD_EN to build the BCD converter and its bcd/bcd_valid ports.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MOD    = 200,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [WIDTH-1:0]              d,
  input  logic                          en,
  input  logic                          up,
  output logic [WIDTH-1:0]              q,
  output logic                          tc
`ifdef MOD_COUNTER_BCD_EN
  ,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          bcd_valid
`endif
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MOD - 1);

  if ((MOD < 2) || (MOD > (1 << WIDTH)) || ((10 ** DIGITS) < MOD)) begin : g_param_chk
    $error("mod_updown_counter: illegal WIDTH/MOD/DIGITS combination");
  end

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_tc_nxt;

  always_comb begin
    w_q_nxt  = r_q;
    w_tc_nxt = 1'b0;
    if (load) begin
      w_q_nxt = ({1'b0, d} < (WIDTH+1)'(MOD)) ? d : LP_MAX;
    end else if (en) begin
      if (up) begin
        if (r_q == LP_MAX) begin
          w_q_nxt  = '0;
          w_tc_nxt = 1'b1;
        end else begin
          w_q_nxt = r_q + 1'b1;
        end
      end else begin
        if (r_q == '0) begin
          w_q_nxt  = LP_MAX;
          w_tc_nxt = 1'b1;
        end else begin
          w_q_nxt = r_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q  <= '0;
      r_tc <= 1'b0;
    end else begin
      r_q  <= w_q_nxt;
      r_tc <= w_tc_nxt;
    end
  end

  assign q  = r_q;
  assign tc = r_tc;

`ifdef MOD_COUNTER_BCD_EN
  bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bcd_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_q         (r_q),
    .i_q_nxt     (w_q_nxt),
    .o_bcd       (bcd),
    .o_bcd_valid (bcd_valid)
  );
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter (default parameters).
module tb_mod_updown_counter;

  localparam int WIDTH = 8;
  localparam int MOD   = 200;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             load  = 1'b0;
  logic [WIDTH-1:0] d     = '0;
  logic             en    = 1'b0;
  logic             up    = 1'b0;
  logic [WIDTH-1:0] q;
  logic             tc;
`ifdef MOD_COUNTER_BCD_EN
  logic [11:0]      bcd;
  logic             bcd_valid;
`endif

  always #5 clk = ~clk;

  mod_updown_counter #(
    .WIDTH  (WIDTH),
    .MOD    (MOD),
    .DIGITS (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .d         (d),
    .en        (en),
    .up        (up),
    .q         (q),
    .tc        (tc)
`ifdef MOD_COUNTER_BCD_EN
    ,
    .bcd       (bcd),
    .bcd_valid (bcd_valid)
`endif
  );

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             tc;
  } exp_t;

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_err    = 0;
  logic [WIDTH-1:0] m_q      = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the model's expectation, compare after the edge.
  task automatic step(input logic l, input logic [WIDTH-1:0] dv, input logic e, input logic u);
    exp_t ex;
    @(negedge clk);
    load = l; d = dv; en = e; up = u;
    ex.tc = 1'b0;
    if (l) begin
      m_q = (int'(dv) < MOD) ? dv : WIDTH'(MOD - 1);
    end else if (e) begin
      if (u) begin
        if (int'(m_q) == MOD - 1) begin m_q = '0; ex.tc = 1'b1; end
        else m_q = m_q + 1'b1;
      end else begin
        if (m_q == '0) begin m_q = WIDTH'(MOD - 1); ex.tc = 1'b1; end
        else m_q = m_q - 1'b1;
      end
    end
    ex.q = m_q;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    ex = sb.pop_front();
    check("q", 32'(q), 32'(ex.q));
    check("tc", 32'(tc), 32'(ex.tc));
  endtask

`ifdef MOD_COUNTER_BCD_EN
  task automatic wait_valid(input int budget);
    int cyc;
    cyc = 0;
    while (!bcd_valid && cyc < budget) begin
      step(1'b0, '0, 1'b0, 1'b0);
      cyc++;
    end
    check("wait_valid", 32'(bcd_valid), 32'd1);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check("rst_q", 32'(q), 32'd0);
    check("rst_tc", 32'(tc), 32'd0);
`ifdef MOD_COUNTER_BCD_EN
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_valid", 32'(bcd_valid), 32'd1);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    repeat (57) step(1'b0, '0, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk);
    #3;
    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    #1;
    check("arst_q", 32'(q), 32'd0);
    check("arst_tc", 32'(tc), 32'd0);
`ifdef MOD_COUNTER_BCD_EN
    check("arst_bcd", 32'(bcd), 32'h0);
    check("arst_valid", 32'(bcd_valid), 32'd1);
`endif
    m_q = '0;
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 8'd199, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);

    step(1'b1, 8'd0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    step(1'b1, 8'd250, 1'b1, 1'b1);
    step(1'b1, 8'd5, 1'b1, 1'b1);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 7) == 0), WIDTH'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

`ifdef MOD_COUNTER_BCD_EN
    wait_valid(30);
    step(1'b1, 8'd137, 1'b0, 1'b0);
    check("valid_after_load", 32'(bcd_valid), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      if (i < 10) check("valid_during_conv", 32'(bcd_valid), 32'd0);
    end
    check("lat_valid", 32'(bcd_valid), 32'd1);
    check("lat_bcd", 32'(bcd), 32'h137);

    step(1'b1, 8'd5, 1'b0, 1'b0);
    wait_valid(30);
    check("bcd_5", 32'(bcd), 32'h005);

    step(1'b1, 8'd137, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 8'd42, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      if (k == 7) begin
        check("mid_bcd", 32'(bcd), 32'h137);
        check("mid_valid", 32'(bcd_valid), 32'd0);
      end
      if (bcd_valid) break;
    end
    check("chg_valid", 32'(bcd_valid), 32'd1);
    check("chg_bcd", 32'(bcd), 32'h042);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
